// File: rtl/tb_mem_pkg.sv
// rtl/tb_mem_pkg.sv - shared types and constants for the testbench memory arbiter
// Optional feature macro used by importers: TB_MEM_ARB_RANDOM_STALL_EN
package tb_mem_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/tb_lfsr16.sv
// rtl/tb_lfsr16.sv - 16-bit Fibonacci LFSR used for random grant stalls
// Instantiated only when TB_MEM_ARB_RANDOM_STALL_EN is defined
module tb_lfsr16
  import tb_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] seed_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_o <= seed_i;
    end else if (en_i) begin
      state_o <= {state_o[14:0], ^(state_o & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// rtl/tb_mem_arbiter.sv - round-robin arbiter sharing one RAM port between instr and data
// Optional random grant stalls: define TB_MEM_ARB_RANDOM_STALL_EN
module tb_mem_arbiter
  import tb_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 20,
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  owner_e last_owner;
  owner_e resp_owner;
  logic   resp_valid;
  logic   stall;

`ifdef TB_MEM_ARB_RANDOM_STALL_EN
  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;

  tb_lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .seed_i  (STALL_SEED),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  assign stall          = (lfsr_state[1:0] == 2'b00);
  assign unused_lfsr_hi = ^lfsr_state[15:2];
`else
  logic unused_seed;

  assign stall       = 1'b0;
  assign unused_seed = ^STALL_SEED;
`endif

  // On a tie the port that did not win last time gets the RAM
  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst_i && !stall) begin
      if (instr_req_i && data_req_i) begin
        if (last_owner == OWNER_INSTR) data_gnt_o  = 1'b1;
        else                           instr_gnt_o = 1'b1;
      end else begin
        instr_gnt_o = instr_req_i;
        data_gnt_o  = data_req_i;
      end
    end
  end

  assign mem_req_o = instr_gnt_o | data_gnt_o;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (data_gnt_o) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_gnt_o) begin
      mem_addr_o = instr_addr_i;
      mem_be_o   = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner <= OWNER_INSTR;
      resp_owner <= OWNER_INSTR;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= mem_req_o;
      if (mem_req_o) begin
        last_owner <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
        resp_owner <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
      end
    end
  end

  // Gating with rst_i drops a response that was in flight when reset arrived
  assign instr_rvalid_o = resp_valid && !rst_i && (resp_owner == OWNER_INSTR);
  assign data_rvalid_o  = resp_valid && !rst_i && (resp_owner == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// tb/tb_tb_mem_arbiter.sv - self-checking bench for tb_mem_arbiter
// Honours TB_MEM_ARB_RANDOM_STALL_EN to model the random stall feature
module tb_tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef TB_MEM_ARB_RANDOM_STALL_EN
  localparam int DBOUND = 20;
`else
  localparam int DBOUND = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, instr_gnt, instr_rvalid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid;
  logic [AW-1:0] data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  tb_mem_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .data_req_i     (data_req),
    .data_addr_i    (data_addr),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h200:   return 32'hDEADBEEF;
      'h201:   return 32'h0BADF00D;
      'h040:   return 32'hAABBCCDD;
      default: return 32'h5A5A0000 ^ i;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Simple single-port RAM: read data appears one cycle after the strobe
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
      end
    end
  end

  // Reference model: last winner, one pending response, shadow memory, stall LFSR
  int          m_last = 0;
  logic        m_pv = 1'b0;
  int          m_pown = 0;
  logic        m_pwe = 1'b0;
  logic [31:0] m_prd = '0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [31:0] m_mem [1024];

  initial begin : cmp
    logic          stl, eig, edg, eir, edr, ewe;
    logic [AW-1:0] eaddr;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;
    int            idx;
    forever begin
      @(negedge clk);
`ifdef TB_MEM_ARB_RANDOM_STALL_EN
      stl = (m_lfsr % 4 == 0);
`else
      stl = 1'b0;
`endif
      eig = 1'b0;
      edg = 1'b0;
      if (!rst && !stl) begin
        if (instr_req && data_req) begin
          if (m_last == 0) edg = 1'b1;
          else             eig = 1'b1;
        end else begin
          eig = instr_req;
          edg = data_req;
        end
      end
      eaddr = '0; ewe = 1'b0; ebe = '0; ewd = '0;
      if (edg) begin
        eaddr = data_addr; ewe = data_we; ebe = data_be; ewd = data_wdata;
      end else if (eig) begin
        eaddr = instr_addr; ebe = {BW{1'b1}};
      end
      chk("instr_gnt", instr_gnt, eig);
      chk("data_gnt", data_gnt, edg);
      chk("mem_req", mem_req, eig | edg);
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_we", mem_we, ewe);
      chk("mem_be", mem_be, ebe);
      chk("mem_wdata", mem_wdata, ewd);
      eir = !rst && m_pv && (m_pown == 0);
      edr = !rst && m_pv && (m_pown == 1);
      chk("instr_rvalid", instr_rvalid, eir);
      chk("data_rvalid", data_rvalid, edr);
      if ((eir || edr) && !m_pwe) begin
        chk("instr_rdata", instr_rdata, m_prd);
        chk("data_rdata", data_rdata, m_prd);
      end
      if (rst) begin
        m_last = 0;
        m_pv = 1'b0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 1024; i++) m_mem[i] = init_word(i);
      end else begin
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_pv = eig | edg;
        if (eig || edg) begin
          m_last = edg ? 1 : 0;
          m_pown = m_last;
          m_pwe = ewe;
          idx = int'(eaddr[11:2]);
          m_prd = m_mem[idx];
          if (ewe)
            for (int b = 0; b < BW; b++)
              if (ebe[b]) m_mem[idx][8*b +: 8] = ewd[8*b +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic [AW-1:0] da, input logic dwe, input logic [BW-1:0] dbe,
                       input logic [DW-1:0] dwd);
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_addr = da; data_we = dwe; data_be = dbe; data_wdata = dwd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic pending;
    int   dwait;
    logic [AW-1:0] pa;
    logic          pwe;
    logic [DW-1:0] pwd;
    rst = 1'b1;
    drive(1'b1, 20'h800, 1'b1, 20'h804, 1'b0, 4'hF, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    tick();

`ifndef TB_MEM_ARB_RANDOM_STALL_EN
    // Instruction-only read
    drive(1'b1, 20'h800, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_igrant", instr_gnt, 1);
    chk("t1_addr", mem_addr, 20'h800);
    tick();
    idle();
    @(negedge clk);
    chk("t1_irvalid", instr_rvalid, 1);
    chk("t1_irdata", instr_rdata, 32'hDEADBEEF);
    chk("t1_drvalid", data_rvalid, 0);

    // Tie after reset alternates D,I,D,I
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 20'h800, 1'b1, 20'h804, 1'b0, 4'hF, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("t2_dgnt", data_gnt, (i % 2 == 0));
        chk("t2_ignt", instr_gnt, (i % 2 == 1));
        if (i % 2 == 1) chk("t2_we", mem_we, 0);
      end
      if (i > 0) begin
        chk("t2_drv", data_rvalid, ((i - 1) % 2 == 0));
        chk("t2_irv", instr_rvalid, ((i - 1) % 2 == 1));
        if ((i - 1) % 2 == 0) chk("t2_drd", data_rdata, 32'h0BADF00D);
      end
      tick();
      if (i == 3) idle();
    end

    // Partial write then read back
    drive(1'b0, '0, 1'b1, 20'h100, 1'b1, 4'b0011, 32'h12345678);
    @(negedge clk);
    chk("t3_wgnt", data_gnt, 1);
    chk("t3_wbe", mem_be, 4'b0011);
    tick();
    drive(1'b0, '0, 1'b1, 20'h100, 1'b0, 4'hF, '0);
    @(negedge clk);
    chk("t3_wrvalid", data_rvalid, 1);
    chk("t3_rgnt", data_gnt, 1);
    chk("t3_ram", ram['h40], 32'hAABB5678);
    tick();
    idle();
    @(negedge clk);
    chk("t3_rrvalid", data_rvalid, 1);
    chk("t3_rdata", data_rdata, 32'hAABB5678);

    // Reset right after a grant drops the response
    tick();
    drive(1'b1, 20'h800, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t4_igrant", instr_gnt, 1);
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("t4_irv", instr_rvalid, 0);
    chk("t4_drv", data_rvalid, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 20'h800, 1'b1, 20'h804, 1'b0, 4'hF, '0);
    @(negedge clk);
    chk("t4_dtie", data_gnt, 1);
    chk("t4_itie", instr_gnt, 0);
    tick();
    idle();
    tick();
`endif

    // Continuous instruction traffic with a data request every third cycle
    pending = 1'b0;
    dwait = 0;
    pa = '0; pwe = 1'b0; pwd = '0;
    for (int c = 0; c < 100; c++) begin
      if (!pending && (c % 3 == 0)) begin
        pending = 1'b1;
        dwait = 0;
        pa = 20'h100 + AW'((c % 4) * 4);
        pwe = (c % 2 == 1);
        pwd = 32'hC0DE0000 + c;
      end
      drive(1'b1, 20'h800, pending, pa, pwe, 4'hF, pwd);
      @(negedge clk);
      chk("t5_onegrant", instr_gnt & data_gnt, 0);
      if (pending) begin
        dwait++;
        if (data_gnt) begin
          chk("t5_dlat", (dwait <= DBOUND), 1);
          pending = 1'b0;
        end else if (dwait > DBOUND) begin
          chk("t5_dtimeout", 0, 1);
          pending = 1'b0;
        end
      end
      tick();
    end
    idle();
    repeat (3) tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
